mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer between the EX/MEM pipeline register and the byte-addressed, big-endian data memory; it is the only master of that memory.
- Accepts one load/store request per valid/ready handshake and drives the memory's Address/DataWr/DMWr/DMCtrl bus.
- Splits misaligned halfword/word accesses into byte accesses over several cycles, does all sign/zero extension itself, and returns a one-cycle response to the pipeline.
- Range-checks addresses and rejects illegal control codes.

Parameters:
- MEM_BYTES, 1024: size of the data memory in bytes. Any access touching byte >= MEM_BYTES is an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  unit can accept a request; high only in IDLE
- ReqWr  in  1  1 = store, 0 = load
- ReqCtrl  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal
- ReqAddr  in  32  byte address
- ReqData  in  32  store data, right-justified
- Address  out  32  memory byte address
- DataWr  out  32  memory write data
- DMWr  out  1  memory write enable
- DMCtrl  out  3  memory size code
- DataRd  in  32  memory read data (combinational)
- RspValid  out  1  one-cycle response pulse
- RspData  out  32  extended load result; 0 for stores and errors
- RspErr  out  1  qualifies RspValid: illegal code, out of range, or misaligned trap

Behaviour:
- States: IDLE, ACCESS, SPLIT, RESP_ERR.
- Handshake:
  - A request is accepted on an edge where ReqValid && ReqReady.
  - The unit latches ReqWr, ReqCtrl, ReqAddr and ReqData.
- Transitions out of IDLE on accept:
  - Illegal code, or ReqAddr + size - 1 >= MEM_BYTES -> RESP_ERR.
  - Aligned (B/BU always; H/HU with addr[0]=0; W with addr[1:0]=0) -> ACCESS.
  - Otherwise -> SPLIT with byte counter k=0, n=2 (H/HU) or n=4 (W).
- ACCESS (one cycle):
  - Drive Address = latched address.
  - DMCtrl = 000 for B/BU stores, 100 for B/BU loads, 001 for H/HU, 010 for W.
  - DataWr = latched data; DMWr = ReqWr.
  - On the edge: RspData <= extended DataRd for loads (0 for stores), RspValid <= 1, go to IDLE.
- SPLIT (n cycles, one per byte k = 0..n-1):
  - Address = addr + k; DMCtrl = 000 for stores, 100 for loads.
  - Byte k of the store value, MSB first (H: [15:8] then [7:0]; W: [31:24] down to [7:0]), is driven on DataWr[7:0]; DMWr = ReqWr.
  - Loads shift a 32-bit assembly register: asm <= {asm[23:0], DataRd[7:0]}.
  - After k = n-1: RspData <= extended asm (0 for stores), RspValid <= 1, go to IDLE.
- RESP_ERR (one cycle): DMWr = 0, no memory access. Next edge: RspValid <= 1, RspErr <= 1, RspData <= 0, go to IDLE.
- Extension rules:
  - B: sign-extend bit 7. BU: zero-extend.
  - H: sign-extend bit 15. HU: zero-extend.
  - W: unchanged.
- Latency, accept edge to RspValid high:
  - 2 cycles aligned or error.
  - 3 cycles misaligned H/HU.
  - 5 cycles misaligned W.
- Back-to-back: ReqReady is high in the same cycle as RspValid, so a new request may be accepted then.
- Outside ACCESS/SPLIT the memory bus is idle: Address=0, DataWr=0, DMCtrl=010, DMWr=0.
- DMWr is decoded from registered state only and must be glitch-free.
- RspValid, RspErr and RspData are registered. RspValid and RspErr return to 0 the cycle after the pulse; RspData holds its value.
- Reset (synchronous): state IDLE, k=0, asm=0, RspValid=0, RspErr=0, RspData=0; memory bus idle.
- Reset mid-SPLIT aborts the access: no further bytes are written, bytes already written stay, and no response is issued.

Optional Feature:
- MISALIGN_TRAP_EN
  - Defined: misaligned H/HU/W requests go to RESP_ERR instead of SPLIT; memory is untouched; 2-cycle error response. SPLIT is not compiled.
  - Undefined: misaligned requests are split as above and RspErr is only used for illegal codes and range errors.

Test Plan:
- Store W 0xAABBCCDD at 0x10, then load W at 0x10 -> store RspValid at cycle 2, RspData=0x00000000; load RspData=0xAABBCCDD, RspErr=0.
- Load B at 0x11 after the word store, then BU at 0x11 -> RspData=0xFFFFFFBB, then 0x000000BB.
- Store H 0x1234 at 0x21 (misaligned, macro off) -> DMWr high 2 cycles: addr 0x21 data 0x12, addr 0x22 data 0x34. Then load HU at 0x21 -> RspData=0x00001234 at cycle 3.
- Store W 0x80000001 at 0x33, then load W at 0x33 (macro off) -> 4 byte writes, load RspValid at cycle 5, RspData=0x80000001. With MISALIGN_TRAP_EN: RspErr=1 at cycle 2, no DMWr.
- Load with ReqCtrl=011, and store W at 0x3FE (MEM_BYTES=1024) -> each gives RspErr=1, RspData=0, DMWr never high.
- Assert rst during the third byte of a misaligned W store -> next cycle state IDLE, ReqReady=1, RspValid never pulses, bytes addr+3 onward unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the EX/MEM register and the
// byte-addressed, big-endian data memory. It accepts one request per
// valid/ready handshake and drives the memory bus. Misaligned H/HU/W accesses
// are split into byte accesses. All sign and zero extension is done here, and
// a one-cycle response is returned to the pipeline.
// Build option: define MISALIGN_TRAP_EN to turn misaligned H/HU/W requests into
// error responses instead of splitting them. The SPLIT path is then not built.
module mem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWr,
    input  logic [2:0]  ReqCtrl,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqData,
    output logic [31:0] Address,
    output logic [31:0] DataWr,
    output logic        DMWr,
    output logic [2:0]  DMCtrl,
    input  logic [31:0] DataRd,
    output logic        RspValid,
    output logic [31:0] RspData,
    output logic        RspErr
);

    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP_ERR} state_t;

    state_t      state_q, state_d;
    logic        wr_q;
    logic [2:0]  ctrl_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        accept;
    logic        req_range_err;
    logic        req_misaligned;
    logic        req_err;
`ifndef MISALIGN_TRAP_EN
    logic [1:0]  k_q;
    logic [1:0]  k_last;
    logic [31:0] asm_q;
    logic [31:0] asm_shift;
`endif

    function automatic logic ctrl_legal(input logic [2:0] c);
        return (c == CTRL_B) || (c == CTRL_H) || (c == CTRL_W) ||
               (c == CTRL_BU) || (c == CTRL_HU);
    endfunction

    function automatic logic [32:0] ctrl_size(input logic [2:0] c);
        case (c)
            CTRL_H, CTRL_HU: return 33'd2;
            CTRL_W:          return 33'd4;
            default:         return 33'd1;
        endcase
    endfunction

    function automatic logic ctrl_misaligned(input logic [2:0] c, input logic [1:0] a);
        case (c)
            CTRL_H, CTRL_HU: return a[0];
            CTRL_W:          return a != 2'b00;
            default:         return 1'b0;
        endcase
    endfunction

    // Load result extension; the signed locals make the sign extension explicit.
    function automatic logic [31:0] extend(input logic [2:0] c, input logic [31:0] v);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = v[7:0];
        h = v[15:0];
        case (c)
            CTRL_B:  return 32'(b);
            CTRL_BU: return {24'h0, v[7:0]};
            CTRL_H:  return 32'(h);
            CTRL_HU: return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [7:0] store_byte(input logic [31:0] d, input logic [1:0] sel);
        case (sel)
            2'd3:    return d[31:24];
            2'd2:    return d[23:16];
            2'd1:    return d[15:8];
            default: return d[7:0];
        endcase
    endfunction

    assign ReqReady       = (state_q == IDLE);
    assign accept         = ReqValid && ReqReady;
    // 33-bit sum so that addresses near 2^32 cannot wrap back into range.
    assign req_range_err  = ({1'b0, ReqAddr} + ctrl_size(ReqCtrl) - 33'd1) >= 33'(MEM_BYTES);
    assign req_misaligned = ctrl_misaligned(ReqCtrl, ReqAddr[1:0]);
`ifdef MISALIGN_TRAP_EN
    assign req_err        = !ctrl_legal(ReqCtrl) || req_range_err || req_misaligned;
`else
    assign req_err        = !ctrl_legal(ReqCtrl) || req_range_err;
    assign k_last         = (ctrl_q == CTRL_W) ? 2'd3 : 2'd1;
    assign asm_shift      = {asm_q[23:0], DataRd[7:0]};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and memory bus drive; the bus is idle outside ACCESS/SPLIT.
    always_comb begin
        state_d = state_q;
        Address = 32'h0;
        DataWr  = 32'h0;
        DMWr    = 1'b0;
        DMCtrl  = CTRL_W;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = RESP_ERR;
                    end
`ifndef MISALIGN_TRAP_EN
                    else if (req_misaligned) begin
                        state_d = SPLIT;
                    end
`endif
                    else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                Address = addr_q;
                DataWr  = data_q;
                DMWr    = wr_q;
                case (ctrl_q)
                    CTRL_H, CTRL_HU: DMCtrl = CTRL_H;
                    CTRL_W:          DMCtrl = CTRL_W;
                    default:         DMCtrl = wr_q ? CTRL_B : CTRL_BU;
                endcase
                state_d = IDLE;
            end
`ifndef MISALIGN_TRAP_EN
            SPLIT: begin
                // Byte k goes to addr+k; store bytes leave MSB first.
                Address = addr_q + {30'h0, k_q};
                DataWr  = {24'h0, store_byte(data_q, k_last - k_q)};
                DMWr    = wr_q;
                DMCtrl  = wr_q ? CTRL_B : CTRL_BU;
                if (k_q == k_last) begin
                    state_d = IDLE;
                end
            end
`endif
            RESP_ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture on accept; only used while the access is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q   <= ReqWr;
            ctrl_q <= ReqCtrl;
            addr_q <= ReqAddr;
            data_q <= ReqData;
        end
    end

    // Byte counter, load assembly and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifndef MISALIGN_TRAP_EN
            k_q      <= 2'd0;
            asm_q    <= 32'h0;
`endif
            RspValid <= 1'b0;
            RspErr   <= 1'b0;
            RspData  <= 32'h0;
        end else begin
            RspValid <= 1'b0;
            RspErr   <= 1'b0;
            case (state_q)
                IDLE: begin
`ifndef MISALIGN_TRAP_EN
                    if (accept) begin
                        k_q   <= 2'd0;
                        asm_q <= 32'h0;
                    end
`endif
                end
                ACCESS: begin
                    RspValid <= 1'b1;
                    RspData  <= wr_q ? 32'h0 : extend(ctrl_q, DataRd);
                end
`ifndef MISALIGN_TRAP_EN
                SPLIT: begin
                    if (!wr_q) begin
                        asm_q <= asm_shift;
                    end
                    if (k_q == k_last) begin
                        k_q      <= 2'd0;
                        RspValid <= 1'b1;
                        RspData  <= wr_q ? 32'h0 : extend(ctrl_q, asm_shift);
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
`endif
                RESP_ERR: begin
                    RspValid <= 1'b1;
                    RspErr   <= 1'b1;
                    RspData  <= 32'h0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: big-endian byte memory model, directed
// request sequence, and a response scoreboard with latency tracking.
// Honours MISALIGN_TRAP_EN for the misaligned-access expectations.
module tb_mem_access_unit;

    localparam time PERIOD = 10;
    localparam time HALF   = 5;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWr;
    logic [2:0]  ReqCtrl;
    logic [31:0] ReqAddr;
    logic [31:0] ReqData;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;
    logic        RspValid;
    logic [31:0] RspData;
    logic        RspErr;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          lat;
        time         t;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;
    } wr_t;

    exp_t        sb[$];
    wr_t         wlog[$];
    logic [7:0]  mem [0:1023];
    logic [9:0]  ra;
    int          vectors = 0;
    int          miscompares = 0;

    mem_access_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWr(ReqWr),
        .ReqCtrl(ReqCtrl), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
        .DataRd(DataRd),
        .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr)
    );

    initial begin
        clk = 1'b0;
        forever #HALF clk = ~clk;
    end

    // Combinational big-endian read port.
    assign ra = Address[9:0];
    always_comb begin
        case (DMCtrl)
            3'b000, 3'b100: DataRd = {24'h0, mem[ra]};
            3'b001, 3'b101: DataRd = {16'h0, mem[ra], mem[ra + 10'd1]};
            default:        DataRd = {mem[ra], mem[ra + 10'd1], mem[ra + 10'd2], mem[ra + 10'd3]};
        endcase
    end

    // Write port; every write is logged for later inspection.
    always @(posedge clk) begin
        if (DMWr) begin
            wlog.push_back({Address, DataWr, DMCtrl});
            case (DMCtrl)
                3'b000, 3'b100: mem[ra] <= DataWr[7:0];
                3'b001, 3'b101: begin
                    mem[ra]         <= DataWr[15:8];
                    mem[ra + 10'd1] <= DataWr[7:0];
                end
                default: begin
                    mem[ra]         <= DataWr[31:24];
                    mem[ra + 10'd1] <= DataWr[23:16];
                    mem[ra + 10'd2] <= DataWr[15:8];
                    mem[ra + 10'd3] <= DataWr[7:0];
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every RspValid pulse.
    initial begin : monitor
        exp_t        e;
        logic        last_v;
        logic [31:0] last_d;
        int          lat;
        last_v = 1'b0;
        last_d = 32'h0;
        forever begin
            @(negedge clk);
            if (RspValid === 1'b1) begin
                vectors++;
                assert (sb.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_rsp: got RspValid=1 data %h, expected no response", RspData);
                end
                if (sb.size() != 0) begin
                    e   = sb.pop_front();
                    lat = int'(($time - HALF - e.t) / PERIOD) + 1;
                    chk("rsp_data", RspData, e.d);
                    chk("rsp_err", {31'h0, RspErr}, {31'h0, e.e});
                    chk("rsp_latency", lat, e.lat);
                end
                last_v = 1'b1;
                last_d = RspData;
            end else begin
                if (last_v) begin
                    chk("rsp_err_clear", {31'h0, RspErr}, 32'h0);
                    chk("rsp_data_hold", RspData, last_d);
                end
                last_v = 1'b0;
            end
        end
    end

    // Called at a negedge; waits (bounded) for ReqReady, drives one request
    // and returns just after the accept edge.
    task automatic issue(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_d,
                         input logic exp_e, input int exp_lat, input bit push);
        int w;
        w = 0;
        while (ReqReady !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready", {31'h0, ReqReady}, 32'h1);
        ReqValid = 1'b1;
        ReqWr    = wr;
        ReqCtrl  = ctrl;
        ReqAddr  = addr;
        ReqData  = data;
        if (push) sb.push_back('{d: exp_d, e: exp_e, lat: exp_lat, t: $time + HALF});
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        ReqWr    = 1'b0;
        ReqCtrl  = 3'b000;
        ReqAddr  = 32'h0;
        ReqData  = 32'h0;
    endtask

    // Returns at a negedge once the scoreboard has drained and the unit is idle.
    task automatic wait_idle();
        int w;
        w = 0;
        while ((sb.size() != 0 || ReqReady !== 1'b1) && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", sb.size(), 32'h0);
    endtask

    task automatic txn(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_d,
                       input logic exp_e, input int exp_lat);
        issue(wr, ctrl, addr, data, exp_d, exp_e, exp_lat, 1'b1);
        wait_idle();
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c);
        if (idx < wlog.size()) begin
            chk({tag, "_addr"}, wlog[idx].a, a);
            chk({tag, "_data"}, wlog[idx].d, d);
            chk({tag, "_ctrl"}, {29'h0, wlog[idx].c}, {29'h0, c});
        end else begin
            chk({tag, "_present"}, wlog.size(), idx + 1);
        end
    endtask

    initial begin : watchdog
        #(PERIOD * 5000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int base;
        rst      = 1'b1;
        ReqValid = 1'b0;
        ReqWr    = 1'b0;
        ReqCtrl  = 3'b000;
        ReqAddr  = 32'h0;
        ReqData  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, ReqReady}, 32'h1);
        chk("rst_rspvalid", {31'h0, RspValid}, 32'h0);
        chk("rst_rsperr", {31'h0, RspErr}, 32'h0);
        chk("rst_rspdata", RspData, 32'h0);
        chk("rst_dmwr", {31'h0, DMWr}, 32'h0);
        chk("rst_dmctrl", {29'h0, DMCtrl}, 32'h2);
        chk("rst_address", Address, 32'h0);
        chk("rst_datawr", DataWr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned word store and reload.
        base = wlog.size();
        txn(1'b1, 3'b010, 32'h10, 32'hAABBCCDD, 32'h0, 1'b0, 2);
        chk("stw_nwrites", wlog.size(), base + 1);
        chk_wr("stw", base, 32'h10, 32'hAABBCCDD, 3'b010);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hAABBCCDD, 1'b0, 2);

        // Byte and halfword extension.
        txn(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBB, 1'b0, 2);
        txn(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000BB, 1'b0, 2);
        txn(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFCCDD, 1'b0, 2);
        txn(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2);

        // Misaligned halfword store and loads.
        base = wlog.size();
        txn(1'b1, 3'b001, 32'h21, 32'h00001234, 32'h0, TRAP, TRAP ? 2 : 3);
        chk("sth_mis_nwrites", wlog.size(), base + (TRAP ? 0 : 2));
`ifndef MISALIGN_TRAP_EN
        chk_wr("sth_mis_b0", base, 32'h21, 32'h12, 3'b000);
        chk_wr("sth_mis_b1", base + 1, 32'h22, 32'h34, 3'b000);
`endif
        txn(1'b0, 3'b101, 32'h21, 32'h0, TRAP ? 32'h0 : 32'h00001234, TRAP, TRAP ? 2 : 3);
        txn(1'b1, 3'b001, 32'h25, 32'h0000F00D, 32'h0, TRAP, TRAP ? 2 : 3);
        txn(1'b0, 3'b001, 32'h25, 32'h0, TRAP ? 32'h0 : 32'hFFFFF00D, TRAP, TRAP ? 2 : 3);

        // Misaligned word store and load.
        base = wlog.size();
        txn(1'b1, 3'b010, 32'h33, 32'h80000001, 32'h0, TRAP, TRAP ? 2 : 5);
        chk("stw_mis_nwrites", wlog.size(), base + (TRAP ? 0 : 4));
`ifndef MISALIGN_TRAP_EN
        chk_wr("stw_mis_b0", base, 32'h33, 32'h80, 3'b000);
        chk_wr("stw_mis_b1", base + 1, 32'h34, 32'h00, 3'b000);
        chk_wr("stw_mis_b2", base + 2, 32'h35, 32'h00, 3'b000);
        chk_wr("stw_mis_b3", base + 3, 32'h36, 32'h01, 3'b000);
`endif
        txn(1'b0, 3'b010, 32'h33, 32'h0, TRAP ? 32'h0 : 32'h80000001, TRAP, TRAP ? 2 : 5);

        // Last legal byte, then illegal codes and range errors.
        txn(1'b1, 3'b000, 32'h3FF, 32'hFFFFFF7E, 32'h0, 1'b0, 2);
        txn(1'b0, 3'b000, 32'h3FF, 32'h0, 32'h0000007E, 1'b0, 2);
        base = wlog.size();
        txn(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 2);
        txn(1'b1, 3'b110, 32'h40, 32'h55, 32'h0, 1'b1, 2);
        txn(1'b1, 3'b010, 32'h3FE, 32'hDEADBEEF, 32'h0, 1'b1, 2);
        txn(1'b0, 3'b001, 32'h3FF, 32'h0, 32'h0, 1'b1, 2);
        txn(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 2);
        chk("err_nwrites", wlog.size(), base);

        // Back-to-back: next request accepted in the response cycle.
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hAABBCCDD, 1'b0, 2, 1'b1);
        @(negedge clk);
        chk("b2b_busy", {31'h0, ReqReady}, 32'h0);
        @(negedge clk);
        chk("b2b_rspvalid", {31'h0, RspValid}, 32'h1);
        chk("b2b_ready", {31'h0, ReqReady}, 32'h1);
        issue(1'b0, 3'b100, 32'h12, 32'h0, 32'h000000CC, 1'b0, 2, 1'b1);
        wait_idle();

`ifndef MISALIGN_TRAP_EN
        // Reset during the third byte of a misaligned word store.
        txn(1'b1, 3'b000, 32'h44, 32'h5C, 32'h0, 1'b0, 2);
        base = wlog.size();
        issue(1'b1, 3'b010, 32'h41, 32'h11223344, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_k2_addr", Address, 32'h43);
        chk("abort_k2_data", DataWr, 32'h33);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'h0, ReqReady}, 32'h1);
        chk("abort_rspvalid", {31'h0, RspValid}, 32'h0);
        chk("abort_dmwr", {31'h0, DMWr}, 32'h0);
        chk("abort_nwrites", wlog.size(), base + 3);
        chk("abort_byte3", {24'h0, mem[10'h44]}, 32'h5C);
        repeat (8) @(negedge clk);
        chk("abort_nwrites_late", wlog.size(), base + 3);
        txn(1'b0, 3'b100, 32'h43, 32'h0, 32'h00000033, 1'b0, 2);
        txn(1'b0, 3'b100, 32'h44, 32'h0, 32'h0000005C, 1'b0, 2);
        txn(1'b0, 3'b001, 32'h41, 32'h0, 32'h00001122, 1'b0, 3);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
